// File: rtl/jtag_ir_dr_path.sv
// jtag_ir_dr_path
//
// Instruction register, data registers (BYPASS, IDCODE, USER) and retimed TDO
// stage of the JTAG port. It is driven by the TAP controller's state-decoded
// strobes. Shift registers update on rising tck. The instruction, the USER
// parallel output and the TDO pair update on falling tck.
//
// Ports:
//   tck, trst            test clock and asynchronous active-low reset
//   reset                controller is in Test-Logic-Reset (synchronous level)
//   tdi                  serial data in
//   captureIR/shiftIR/updateIR, captureDR/shiftDR/updateDR
//                        TAP state strobes (level, one per state)
//   select               1 = IR path drives TDO, 0 = DR path
//   tdo_en               controller is in Shift-IR or Shift-DR
//   tdo, tdo_oe          serial data out and pad output enable (falling tck)
//   instr                current (updated) instruction
//   user_din             parallel value captured into the USER register
//   user_dout            last value written through the USER register
//   user_update          one-tck pulse when user_dout is loaded
module jtag_ir_dr_path #(
    parameter int unsigned           IR_WIDTH   = 4,
    parameter logic [31:0]           IDCODE_VAL = 32'h1000_563D,
    parameter int unsigned           USER_WIDTH = 16,
    parameter logic [IR_WIDTH-1:0]   OP_IDCODE  = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]   OP_USER    = IR_WIDTH'(8)
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  reset,
    input  logic                  tdi,
    input  logic                  captureIR,
    input  logic                  shiftIR,
    input  logic                  updateIR,
    input  logic                  captureDR,
    input  logic                  shiftDR,
    input  logic                  updateDR,
    input  logic                  select,
    input  logic                  tdo_en,
    output logic                  tdo,
    output logic                  tdo_oe,
    output logic [IR_WIDTH-1:0]   instr,
    input  logic [USER_WIDTH-1:0] user_din,
    output logic [USER_WIDTH-1:0] user_dout,
    output logic                  user_update
);

    logic [IR_WIDTH-1:0]   irSr;
    logic                  bypassSr;
    logic [31:0]           idcodeSr;
    logic [USER_WIDTH-1:0] userSr;

    logic selIdcode;
    logic selUser;
    logic selBypass;
    logic drTdo;

    // ------------------------------------------------------------------
    // Instruction shift register (rising tck). Capture loads ...01 so the
    // first two bits out are the mandatory 1,0 pattern.
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            irSr <= '0;
        end else if (captureIR) begin
            irSr <= IR_WIDTH'(1);
        end else if (shiftIR) begin
            irSr <= {tdi, irSr[IR_WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Instruction register (falling tck). Updating half a cycle into
    // Update-IR keeps the DR selection stable before the next Capture-DR.
    // ------------------------------------------------------------------
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            instr <= OP_IDCODE;
        end else if (reset) begin
            instr <= OP_IDCODE;
        end else if (updateIR) begin
            instr <= irSr;
        end
    end

    // Unknown opcodes, including all-ones, fall through to BYPASS.
    always_comb begin
        selIdcode = (instr == OP_IDCODE);
        selUser   = (instr == OP_USER);
        selBypass = !selIdcode && !selUser;
    end

    // ------------------------------------------------------------------
    // Data registers (rising tck). Only the selected register moves.
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypassSr <= 1'b0;
        end else if (selBypass) begin
            if (captureDR) begin
                bypassSr <= 1'b0;
            end else if (shiftDR) begin
                bypassSr <= tdi;
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            idcodeSr <= '0;
        end else if (selIdcode) begin
            if (captureDR) begin
                idcodeSr <= IDCODE_VAL;
            end else if (shiftDR) begin
                idcodeSr <= {tdi, idcodeSr[31:1]};
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            userSr <= '0;
        end else if (selUser) begin
            if (captureDR) begin
                userSr <= user_din;
            end else if (shiftDR) begin
                userSr <= {tdi, userSr[USER_WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        if (selIdcode) begin
            drTdo = idcodeSr[0];
        end else if (selUser) begin
            drTdo = userSr[0];
        end else begin
            drTdo = bypassSr;
        end
    end

    // ------------------------------------------------------------------
    // Falling-edge output stage: TDO retiming and USER parallel update.
    // tdo keeps tracking the mux while tdo_oe is low; the pad ignores it.
    // ------------------------------------------------------------------
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo    <= select ? irSr[0] : drTdo;
            tdo_oe <= tdo_en;
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            user_dout   <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= updateDR && selUser;
            if (updateDR && selUser) begin
                user_dout <= userSr;
            end
        end
    end

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Bench for jtag_ir_dr_path. Builds a table of TAP-state vectors with their
// expected outputs, applies them one state per tck, and compares through an
// expectation queue at the falling edge of each state. Hand-written
// sequences cover the reset state and an asynchronous trst mid-shift.
module tb_jtag_ir_dr_path;

    localparam logic [31:0] IDV = 32'h1000_563D;
    localparam logic [15:0] UDIN = 16'hA55A;
    localparam logic [15:0] UWR = 16'h1234;

    // {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] CIR  = 6'b100000;
    localparam logic [5:0] SIR  = 6'b010000;
    localparam logic [5:0] UIR  = 6'b001000;
    localparam logic [5:0] CDR  = 6'b000100;
    localparam logic [5:0] SDR  = 6'b000010;
    localparam logic [5:0] UDR  = 6'b000001;

    typedef struct {
        string       name;
        logic [5:0]  strb;
        logic        sel;
        logic        en;
        logic        rst;
        logic        tdi;
        logic        expTdo;
        logic        expOe;
        logic [3:0]  expInstr;
        logic        expUpd;
        logic [15:0] expDout;
    } vec_t;

    logic        tck = 1'b0;
    logic        trst;
    logic        reset;
    logic        tdi;
    logic        captureIR, shiftIR, updateIR;
    logic        captureDR, shiftDR, updateDR;
    logic        select;
    logic        tdo_en;
    logic        tdo;
    logic        tdo_oe;
    logic [3:0]  instr;
    logic [15:0] user_din;
    logic [15:0] user_dout;
    logic        user_update;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t expQ[$];

    // Expected architectural state, tracked while the table is built.
    logic [3:0]  curInstr = 4'b0001;
    logic [15:0] curDout  = 16'h0000;
    logic        curIrLsb = 1'b0;

    jtag_ir_dr_path dut (
        .tck        (tck),
        .trst       (trst),
        .reset      (reset),
        .tdi        (tdi),
        .captureIR  (captureIR),
        .shiftIR    (shiftIR),
        .updateIR   (updateIR),
        .captureDR  (captureDR),
        .shiftDR    (shiftDR),
        .updateDR   (updateDR),
        .select     (select),
        .tdo_en     (tdo_en),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .instr      (instr),
        .user_din   (user_din),
        .user_dout  (user_dout),
        .user_update(user_update)
    );

    always #5 tck = ~tck;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [5:0] strb, input logic sel,
                          input logic en, input logic rst, input logic tdiV,
                          input logic expTdo, input logic expUpd);
        vec_t v;
        v.name     = name;
        v.strb     = strb;
        v.sel      = sel;
        v.en       = en;
        v.rst      = rst;
        v.tdi      = tdiV;
        v.expTdo   = expTdo;
        v.expOe    = en;
        v.expInstr = curInstr;
        v.expUpd   = expUpd;
        v.expDout  = curDout;
        vecs.push_back(v);
    endtask

    // Capture-IR, four Shift-IR, Exit1-IR, Update-IR. With ...01 captured the
    // bits out during the shift are always 1,0,0,0.
    task automatic irLoad(input logic [3:0] value);
        addVec("capIR", CIR, 1'b1, 1'b0, 1'b0, 1'b0, curIrLsb, 1'b0);
        for (int i = 0; i < 4; i++) begin
            addVec($sformatf("shiftIR%0d", i), SIR, 1'b1, 1'b1, 1'b0, value[i], (i == 0), 1'b0);
        end
        addVec("exit1IR", NONE, 1'b1, 1'b0, 1'b0, 1'b0, value[0], 1'b0);
        curInstr = value;
        addVec("updIR", UIR, 1'b1, 1'b0, 1'b0, 1'b0, value[0], 1'b0);
        curIrLsb = value[0];
    endtask

    task automatic applyVec(input vec_t v, input int idx);
        vec_t e;
        {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = v.strb;
        select = v.sel;
        tdo_en = v.en;
        reset  = v.rst;
        tdi    = v.tdi;
        expQ.push_back(v);
        @(negedge tck);
        #1;
        e = expQ.pop_front();
        check($sformatf("%s#%0d.tdo", e.name, idx), 32'(tdo), 32'(e.expTdo));
        check($sformatf("%s#%0d.tdo_oe", e.name, idx), 32'(tdo_oe), 32'(e.expOe));
        check($sformatf("%s#%0d.instr", e.name, idx), 32'(instr), 32'(e.expInstr));
        check($sformatf("%s#%0d.user_update", e.name, idx), 32'(user_update), 32'(e.expUpd));
        check($sformatf("%s#%0d.user_dout", e.name, idx), 32'(user_dout), 32'(e.expDout));
        @(posedge tck);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, ".tdo"}, 32'(tdo), 32'h0);
        check({tag, ".tdo_oe"}, 32'(tdo_oe), 32'h0);
        check({tag, ".instr"}, 32'(instr), 32'h1);
        check({tag, ".user_dout"}, 32'(user_dout), 32'h0);
        check({tag, ".user_update"}, 32'(user_update), 32'h0);
    endtask

    initial begin
        vec_t fin;
        {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = NONE;
        select   = 1'b0;
        tdo_en   = 1'b0;
        reset    = 1'b0;
        tdi      = 1'b0;
        user_din = UDIN;
        trst     = 1'b1;
        #1 trst  = 1'b0;
        #2;
        checkResetOutputs("resetState");

        // IDCODE read straight after reset: 32 bits LSB first, then zeros.
        addVec("idle", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec("capDR", CDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            addVec("idShift", SDR, 1'b0, 1'b1, 1'b0, 1'b0, IDV[i], 1'b0);
        end
        addVec("exit1DR", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec("updDR", UDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // BYPASS via all-ones: one-bit delay through the DR path.
        irLoad(4'b1111);
        addVec("bpCap", CDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec("bpShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec("bpShift", SDR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec("bpShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec("bpShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        addVec("bpExit1", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec("bpUpd", UDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Undefined opcode behaves as BYPASS; ones shifted here must not reach
        // the IDCODE or USER registers.
        irLoad(4'b0101);
        addVec("undefCap", CDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec("undefShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec("undefShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        addVec("undefShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        addVec("undefExit1", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec("undefUpd", UDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        irLoad(4'b0001);
        addVec("idKept", SDR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec("idKept", SDR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // USER: read A55A, write 1234, single-cycle user_update.
        irLoad(4'b1000);
        addVec("userCap", CDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            addVec("userShift", SDR, 1'b0, 1'b1, 1'b0, UWR[i], UDIN[i], 1'b0);
        end
        addVec("userExit1", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        curDout = UWR;
        addVec("userUpd", UDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        addVec("userIdle", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid USER shift: instr back to IDCODE, user_dout untouched.
        // USER holds F4AB after three 1s shifted into A55A; its LSB is still
        // muxed out on the falling edge that also switches instr.
        addVec("rsCap", CDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            addVec("rsShift", SDR, 1'b0, 1'b1, 1'b0, 1'b1, UDIN[i], 1'b0);
        end
        curInstr = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            addVec("tlr", NONE, 1'b0, 1'b0, 1'b1, 1'b0, (i == 0), 1'b0);
        end
        addVec("postTlr", NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lead-in to the asynchronous trst check: USER shift in progress.
        irLoad(4'b1000);
        addVec("atCap", CDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec("atShift", SDR, 1'b0, 1'b1, 1'b0, 1'b0, UDIN[0], 1'b0);
        addVec("atShift", SDR, 1'b0, 1'b1, 1'b0, 1'b0, UDIN[1], 1'b0);

        @(posedge tck);
        #1 trst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyVec(vecs[i], i);
        end

        // Asynchronous trst between edges while Shift-DR is live.
        check("preTrst.tdo", 32'(tdo), 32'h1);
        check("preTrst.tdo_oe", 32'(tdo_oe), 32'h1);
        check("preTrst.user_dout", 32'(user_dout), 32'(UWR));
        #2 trst = 1'b0;
        #1;
        checkResetOutputs("asyncTrst");
        @(posedge tck);
        checkResetOutputs("trstHeld");
        #1 trst = 1'b1;

        curInstr = 4'b0001;
        curDout  = 16'h0000;
        fin.name     = "afterTrst";
        fin.strb     = NONE;
        fin.sel      = 1'b0;
        fin.en       = 1'b0;
        fin.rst      = 1'b0;
        fin.tdi      = 1'b0;
        fin.expTdo   = 1'b0;
        fin.expOe    = 1'b0;
        fin.expInstr = curInstr;
        fin.expUpd   = 1'b0;
        fin.expDout  = curDout;
        applyVec(fin, vecs.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_ir_dr_path.md
# jtag_ir_dr_path

Instruction register, data registers and TDO output stage of the JTAG port, directly downstream of `spec_tap_controller`. It consumes the controller's state-decoded strobes (capture/shift/update for IR and DR, `select`, `tdo_en`, synchronous `reset`). It holds the current instruction and the BYPASS, IDCODE and USER data registers. It drives the retimed `tdo`/`tdo_oe` pair and a parallel user-register interface into the core.

## Interface
- `IR_WIDTH`, 4, instruction register width (>= 2)
- `IDCODE_VAL`, 32'h1000_563D, value captured by IDCODE; bit 0 must be 1
- `USER_WIDTH`, 16, USER data register width
- `OP_IDCODE`, 4'b0001, IDCODE opcode (reset instruction)
- `OP_USER`, 4'b1000, USER opcode; all-ones is BYPASS; every other opcode also selects BYPASS
- `tck`  in  1  JTAG test clock; the only clock
- `trst`  in  1  asynchronous, active-low reset
- `reset`  in  1  controller in Test-Logic-Reset (synchronous, level)
- `tdi`  in  1  serial data in
- `captureIR`, `shiftIR`, `updateIR`  in  1 each  IR state strobes (level, one per TAP state)
- `captureDR`, `shiftDR`, `updateDR`  in  1 each  DR state strobes
- `select`  in  1  1 = IR path drives TDO, 0 = DR path
- `tdo_en`  in  1  controller is in Shift-IR or Shift-DR
- `tdo`  out  1  serial data out, changes on falling `tck`
- `tdo_oe`  out  1  output enable for the TDO pad
- `instr`  out  IR_WIDTH  current (updated) instruction
- `user_din`  in  USER_WIDTH  parallel value captured into USER DR
- `user_dout`  out  USER_WIDTH  last value written through USER DR
- `user_update`  out  1  one-`tck` pulse when `user_dout` is loaded

## Operation
- IR shift register `ir_sr` updates on rising `tck`:
  - `captureIR`: load {0…0,01}.
  - else `shiftIR`: `ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}`, LSB first.
  - Otherwise hold.
- `instr` updates on falling `tck`:
  - `reset`: load `OP_IDCODE`; this takes priority over `updateIR`.
  - else `updateIR`: load `ir_sr`.
- Decoding of `instr` is combinational:
  - `OP_IDCODE` selects the 32-bit IDCODE register.
  - `OP_USER` selects the USER register.
  - Anything else, including all-ones, selects the 1-bit BYPASS register.
- The selected DR updates on rising `tck`. Unselected DRs hold.
  - BYPASS: `captureDR` loads 0; `shiftDR` loads `tdi`.
  - IDCODE: `captureDR` loads `IDCODE_VAL`; `shiftDR` shifts right with `tdi` into the MSB.
  - USER: `captureDR` loads `user_din`; `shiftDR` shifts right with `tdi` into the MSB.
- USER update:
  - On falling `tck` with `updateDR` and `instr==OP_USER`, `user_dout` loads the USER shift register and `user_update` is set.
  - `user_update` clears on the next falling `tck`.
- TDO stage, on falling `tck`:
  - `tdo <= select ? ir_sr[0] : selected_dr[0]`.
  - `tdo_oe <= tdo_en`.
  - When `tdo_oe` is 0, `tdo` still tracks the mux; the pad ignores it.
- Simultaneous strobes: capture outranks shift on the same edge. The controller guarantees only one of capture/shift/update is active.

## Timing
- `trst` low (asynchronous) forces:
  - `ir_sr`=0, `instr`=`OP_IDCODE`;
  - BYPASS, IDCODE and USER shift registers = 0;
  - `user_dout`=0, `user_update`=0, `tdo`=0, `tdo_oe`=0.
- Release of `trst` is synchronous to `tck` at both edges; state holds until the next active edge.
- Capture happens on the rising edge that exits the Capture state.
- The first shifted bit appears on `tdo` at the falling edge in Shift, i.e. the LSB of the captured value is valid for the first rising edge that samples in Shift.
- Each shift moves one bit per `tck`. An N-bit register is fully read after N rising edges in Shift, and the next bit out is the first `tdi` bit shifted in.
- `instr` changes half a cycle after entering Update-IR, so the DR selection is stable before the next Capture-DR.
- `user_update` is high for exactly one `tck` period, starting at the falling edge in Update-DR.
- If `reset` is asserted mid-shift, `instr` returns to IDCODE on the next falling edge. Partially shifted `ir_sr` and DR contents are discarded: the next capture overwrites them, and `user_dout` is not updated.
- Exiting Shift without passing through Update (e.g. Exit1→Pause→Exit2→Shift) preserves shift-register contents.

## Test plan
- Pulse `trst`, then drive Capture-DR plus 32 Shift-DR cycles with `tdi`=0 → `tdo` serialises 32'h1000_563D LSB first, then 0s; `tdo_oe`=1 only during the shifts.
- Capture-IR, then shift in 4'b1111, then Update-IR → `tdo` during the IR shift shows 1,0,0,0; `instr`=4'b1111. Shifting DR with `tdi`=1,0,1,1 gives `tdo`=0,1,0,1 (one-bit bypass delay).
- Load `instr`=4'b0101 (undefined opcode) → DR path behaves as BYPASS; IDCODE and USER registers are unchanged.
- Load `OP_USER` with `user_din`=16'hA55A, then Capture-DR, then shift in 16'h1234, then Update-DR → `tdo` reads 16'hA55A LSB first; `user_dout`=16'h1234; `user_update` is high for exactly one `tck`.
- During a USER shift, hold TMS high for 5 cycles → `instr` returns to 4'b0001; `user_dout` is unchanged; `user_update` is never asserted.
- Assert `trst` low asynchronously mid-Shift-DR → all outputs go to their reset values immediately, without a `tck` edge.
